// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD MM:SS stopwatch.
// bcd2_t holds one two-digit field; int_to_bcd2 builds wrap constants.
package stopwatch_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned SEC_WRAP = 59;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    function automatic bcd2_t int_to_bcd2(input int unsigned value);
        bcd2_t r;
        r.tens = BCD_W'((value / 10) % 10);
        r.ones = BCD_W'(value % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps WRAP -> 00.
// wrap_out flags the increment that causes the wrap, for carry chaining.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned WRAP = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             wrap_out
);

    localparam bcd2_t WrapBcd = int_to_bcd2(WRAP);

    bcd2_t cnt_q, cnt_d;
    logic  at_wrap;

    assign at_wrap  = (cnt_q == WrapBcd);
    assign wrap_out = inc & at_wrap;
    assign tens     = cnt_q.tens;
    assign ones     = cnt_q.ones;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (at_wrap) begin
                cnt_d = '0;
            end else if (cnt_q.ones == BCD_W'(9)) begin
                cnt_d.tens = cnt_q.tens + BCD_W'(1);
                cnt_d.ones = '0;
            end else begin
                cnt_d.ones = cnt_q.ones + BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch advanced by edges of the divided tick_in square wave.
// Supports run/pause, clear and per-field adjust; step pulses alongside each digit change.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_WRAP   = 59,
    parameter int unsigned BOTH_EDGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             run_toggle,
    input  logic             clear,
    input  logic             adj_en,
    input  logic             adj_sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             step
);

    logic tick_q;
    logic running_q, running_d;
    logic step_q, step_d;
    logic rise, fall, adv;
    logic sec_inc, min_inc, sec_wrap, min_wrap_unused;

    assign rise = tick_in & ~tick_q;
    assign fall = ~tick_in & tick_q;
    assign adv  = rise | ((BOTH_EDGES != 0) & fall);

    // clear wins over any coincident advance; increments use pre-toggle running.
    always_comb begin
        sec_inc   = 1'b0;
        min_inc   = 1'b0;
        running_d = running_q ^ run_toggle;
        if (!clear) begin
            if (adj_en) begin
                sec_inc = adv & ~adj_sel;
                min_inc = adv & adj_sel;
            end else begin
                sec_inc = running_q & adv;
                min_inc = running_q & adv & sec_wrap;
            end
        end
        step_d = sec_inc | min_inc;
    end

    bcd_mod_counter #(
        .WRAP(SEC_WRAP)
    ) u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .inc     (sec_inc),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .wrap_out(sec_wrap)
    );

    bcd_mod_counter #(
        .WRAP(MIN_WRAP)
    ) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .inc     (min_inc),
        .tens    (min_tens),
        .ones    (min_ones),
        .wrap_out(min_wrap_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            tick_q    <= tick_in;
            running_q <= running_d;
            step_q    <= step_d;
        end
    end

    assign running = running_q;
    assign step    = step_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: one rising-edge-only instance and one
// both-edges instance share all inputs; expected values are hand-computed.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst_n, tick_in, run_toggle, clear, adj_en, adj_sel;
    logic [3:0] mt1, mo1, st1, so1, mt2, mo2, st2, so2;
    logic running1, step1, running2, step2;

    int n_checks = 0;
    int n_err    = 0;
    int steps1   = 0;
    int steps2   = 0;

    always #5 clk = ~clk;

    stopwatch_counter #(
        .MIN_WRAP  (59),
        .BOTH_EDGES(0)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .run_toggle(run_toggle),
        .clear     (clear),
        .adj_en    (adj_en),
        .adj_sel   (adj_sel),
        .min_tens  (mt1),
        .min_ones  (mo1),
        .sec_tens  (st1),
        .sec_ones  (so1),
        .running   (running1),
        .step      (step1)
    );

    stopwatch_counter #(
        .MIN_WRAP  (59),
        .BOTH_EDGES(1)
    ) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .run_toggle(run_toggle),
        .clear     (clear),
        .adj_en    (adj_en),
        .adj_sel   (adj_sel),
        .min_tens  (mt2),
        .min_ones  (mo2),
        .sec_tens  (st2),
        .sec_ones  (so2),
        .running   (running2),
        .step      (step2)
    );

    wire [15:0] disp1 = {mt1, mo1, st1, so1};
    wire [15:0] disp2 = {mt2, mo2, st2, so2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (step1 === 1'b1) steps1++;
            if (step2 === 1'b1) steps2++;
        end
    endtask

    task automatic rise_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc();
            tick_in = 1'b0;
            cyc();
        end
    endtask

    task automatic pulse_toggle();
        run_toggle = 1'b1;
        cyc();
        run_toggle = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        tick_in    = 1'b0;
        run_toggle = 1'b0;
        clear      = 1'b0;
        adj_en     = 1'b0;
        adj_sel    = 1'b0;
        cyc(3);
        chk("reset_digits", {16'h0, disp1}, 32'h0000);
        chk("reset_running", {31'h0, running1}, 32'h0);
        chk("reset_step", {31'h0, step1}, 32'h0);
        rst_n = 1'b1;
        cyc(2);
        chk("release_no_edge", {16'h0, disp1}, 32'h0000);

        // 1: run and count 61 seconds
        pulse_toggle();
        chk("t1_running", {31'h0, running1}, 32'h1);
        steps1 = 0;
        rise_n(61);
        chk("t1_digits", {16'h0, disp1}, 32'h0101);
        chk("t1_steps", steps1, 61);

        // 2: preload 59:59 via adjust, then one running tick wraps to 00:00
        adj_en  = 1'b1;
        adj_sel = 1'b0;
        rise_n(58);
        adj_sel = 1'b1;
        rise_n(58);
        chk("t2_preload", {16'h0, disp1}, 32'h5959);
        adj_en  = 1'b0;
        adj_sel = 1'b0;
        cyc();
        tick_in = 1'b1;
        cyc();
        chk("t2_wrap_digits", {16'h0, disp1}, 32'h0000);
        chk("t2_wrap_step", {31'h0, step1}, 32'h1);
        tick_in = 1'b0;
        cyc();
        chk("t2_step_one_cycle", {31'h0, step1}, 32'h0);

        // 3: clear coincident with a rise at 00:07
        rise_n(7);
        chk("t3_pre", {16'h0, disp1}, 32'h0007);
        clear   = 1'b1;
        tick_in = 1'b1;
        cyc();
        chk("t3_clear_digits", {16'h0, disp1}, 32'h0000);
        chk("t3_clear_step", {31'h0, step1}, 32'h0);
        chk("t3_running_kept", {31'h0, running1}, 32'h1);
        clear   = 1'b0;
        tick_in = 1'b0;
        cyc();
        chk("t3_no_late_adv", {16'h0, disp1}, 32'h0000);

        // 4: paused, minutes-only adjust across the wrap
        pulse_toggle();
        chk("t4_paused", {31'h0, running1}, 32'h0);
        rise_n(2);
        chk("t4_paused_hold", {16'h0, disp1}, 32'h0000);
        adj_en  = 1'b1;
        adj_sel = 1'b1;
        rise_n(58);
        adj_sel = 1'b0;
        rise_n(20);
        chk("t4_preload", {16'h0, disp1}, 32'h5820);
        adj_sel = 1'b1;
        cyc(2);
        chk("t4_sel_switch_hold", {16'h0, disp1}, 32'h5820);
        rise_n(3);
        chk("t4_min_wrap_no_carry", {16'h0, disp1}, 32'h0120);

        // 5: double-rate instance, then a long high level advances only once
        adj_en  = 1'b0;
        adj_sel = 1'b0;
        pulse_clear();
        pulse_toggle();
        chk("t5_running", {31'h0, running2}, 32'h1);
        chk("t5_cleared", {16'h0, disp2}, 32'h0000);
        for (int p = 0; p < 4; p++) begin
            tick_in = 1'b1;
            cyc(3);
            tick_in = 1'b0;
            cyc(3);
        end
        chk("t5_both_edges", {16'h0, disp2}, 32'h0008);
        chk("t5_rise_only", {16'h0, disp1}, 32'h0004);
        steps2  = 0;
        tick_in = 1'b1;
        cyc(100);
        chk("t5_hold_both", {16'h0, disp2}, 32'h0009);
        chk("t5_hold_rise", {16'h0, disp1}, 32'h0005);
        chk("t5_hold_steps", steps2, 1);

        // 6: asynchronous reset mid-count at 12:34
        tick_in = 1'b0;
        pulse_clear();
        adj_en  = 1'b1;
        adj_sel = 1'b1;
        rise_n(12);
        adj_sel = 1'b0;
        rise_n(34);
        adj_en = 1'b0;
        cyc();
        chk("t6_preload", {16'h0, disp1}, 32'h1234);
        chk("t6_pre_running", {31'h0, running1}, 32'h1);
        #3;
        rst_n = 1'b0;
        #2;
        chk("t6_async_digits", {16'h0, disp1}, 32'h0000);
        chk("t6_async_running", {31'h0, running1}, 32'h0);
        tick_in = 1'b1;
        cyc(2);
        rst_n  = 1'b1;
        steps1 = 0;
        cyc(20);
        chk("t6_held_high_digits", {16'h0, disp1}, 32'h0000);
        chk("t6_held_high_steps", steps1, 0);
        chk("t6_still_paused", {31'h0, running1}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Downstream consumer of the slow divided clock from the clock divider. It samples that square wave in the system clock domain and detects its edges. Each detected edge advances a BCD MM:SS stopwatch, with run/pause, clear and a per-field adjust mode. Its outputs feed the 7-segment display driver.

Parameters:
MIN_WRAP, 59, largest minutes value (0..99) before minutes wrap to 00
BOTH_EDGES, 0, 0 = advance on rising edge of tick_in only; 1 = advance on both edges (double rate)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_in  input  1  slow square wave from the divider, synchronous to clk
run_toggle  input  1  single-cycle pulse; toggles running/paused
clear  input  1  single-cycle pulse; zeroes all digits
adj_en  input  1  level; 1 = adjust mode
adj_sel  input  1  level; 0 = adjust seconds, 1 = adjust minutes
min_tens  output  4  BCD minutes tens digit
min_ones  output  4  BCD minutes ones digit
sec_tens  output  4  BCD seconds tens digit (0..5)
sec_ones  output  4  BCD seconds ones digit
running  output  1  1 = counting enabled
step  output  1  one-cycle pulse on every clk edge where the digits advanced

Behaviour:
- Reset (rst_n=0, asynchronous): all digits 0, running=0, step=0, tick_q=0. Release is taken on the next clk edge; no edge is detected in the first cycle after release if tick_in=0.
- Edge detect: tick_q <= tick_in every cycle.
  - rise = tick_in & ~tick_q.
  - fall = ~tick_in & tick_q.
  - adv = rise, or (BOTH_EDGES & fall).
  - At most one adv per level change; a held level never re-triggers.
- Run control: run_toggle=1 flips running on that clk edge.
- Priority per clk edge, highest first:
  - clear: digits <= 00:00 and step=0. running is unchanged, and a coincident adv is discarded.
  - adj_en=1 and adv: only the selected field increments. Seconds wrap 59->00 and minutes wrap MIN_WRAP->00, with no carry between fields. This works regardless of running. step=1.
  - adj_en=0, running=1 and adv: seconds increment. At 59 they wrap to 00 and minutes increment, with minutes wrapping MIN_WRAP->00. step=1.
  - Otherwise digits hold and step=0.
- run_toggle and adv in the same cycle: the advance uses the pre-toggle running value.
- Latency: digits change on the same clk edge at which adv is high, so they are visible one cycle after tick_in is first sampled at its new level.
- BCD rules:
  - Ones digits count 0..9 and carry into tens.
  - Seconds tens count 0..5.
  - Minutes compare against the BCD encoding of MIN_WRAP.
  - Digits never hold non-BCD values.
- Mid-operation reset clears everything immediately, including running. A pending edge is lost.
- Changing adj_sel or adj_en takes effect on the next adv; no digit changes on the switch itself.

Decomposition:
- Package stopwatch_pkg:
  - BCD_W=4
  - SEC_WRAP=59
  - typedef bcd2_t (struct {tens, ones})
  - function int_to_bcd2 for the wrap constant
- Sub-module bcd_mod_counter:
  - Purpose: two-digit BCD counter with parameter WRAP.
  - Inputs: clk, rst_n, clr, inc.
  - Outputs: tens, ones, and wrap_out, which is combinational and high when inc is set and the value equals WRAP.
  - Instantiated twice:
    - seconds: WRAP=59
    - minutes: WRAP=MIN_WRAP
  - Minutes inc = (adj_en ? adv & adj_sel : running & adv & sec_wrap_out).
  - Seconds inc = (adj_en ? adv & ~adj_sel : running & adv).

Test Plan:
1. Reset, then run_toggle, then 61 rising edges of tick_in (BOTH_EDGES=0) -> 01:01, running=1, exactly 61 step pulses.
2. Preload to 59:59 via adjust mode, set adj_en=0 and running, then one rising edge -> 00:00, step=1 in that cycle.
3. running=1 and clear asserted in the same cycle as rise at 00:07 -> 00:00, step=0, running still 1.
4. Paused, adj_en=1, adj_sel=1, 3 rising edges from 58:20 -> 01:20 (58->59->00->01); seconds unchanged, no carry.
5. BOTH_EDGES=1, running, 4 full tick_in periods -> 00:08; tick_in held high 100 cycles -> no extra advance.
6. rst_n pulsed low mid-count at 12:34, asynchronously between clk edges -> outputs 00:00 and running=0 before the next clk edge; held-high tick_in after release causes no advance.
